// File: rtl/if_fetch_predictor.sv
// ============================================================================
// if_fetch_predictor - PC owner and fetch stage with a saturating-counter BHT
// Optional IF_PRED_STATS_EN adds resolve/mispredict statistics counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_predictor #(
    parameter int               XLEN        = 32,
    parameter int               BHT_ENTRIES = 64,
    parameter int               CNT_WIDTH   = 2,
    parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            id_branch,
    input  logic            id_jmp,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imme,
    input  logic            ex_resolve,
    input  logic            ex_taken,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    output logic            if_pred_taken,
    output logic            if_flush,
    output logic            if_hold,
    output logic            if_err
`ifdef IF_PRED_STATS_EN
   ,output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int                   IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [XLEN-1:0]      PC_STEP  = XLEN'(4);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      base_q, base_d;
    logic [XLEN-1:0]      imme_q, imme_d;
    logic                 taken_q, taken_d;
    logic                 flush_q, flush_d;
    logic                 err_q, err_d;
    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [BHT_ENTRIES];
    logic [CNT_WIDTH-1:0] cnt_d [BHT_ENTRIES];

    logic [IDX_W-1:0]     id_idx;
    logic [IDX_W-1:0]     base_idx;
    logic                 pred;
    logic                 mispred;
    logic                 resolving;
    logic [XLEN-1:0]      id_target;
    logic [XLEN-1:0]      id_fallthru;

    assign imem_addr     = pc_q;
    assign imem_en       = !stall && !if_hold;
    assign if_pred_taken = taken_q;
    assign if_flush      = flush_q && !stall;
    assign if_hold       = (state_q == ST_PENDING) && id_branch && !ex_resolve;
    assign if_err        = err_q;

    // Prediction reads the registered table, so a same-cycle update at the
    // same index is not visible until the next cycle.
    always_comb begin
        id_idx      = id_pc[IDX_W+1:2];
        base_idx    = base_q[IDX_W+1:2];
        pred        = cnt_q[id_idx][CNT_WIDTH-1];
        mispred     = (ex_taken != taken_q);
        resolving   = ex_resolve && (state_q == ST_PENDING);
        id_target   = id_pc + id_imme;
        id_fallthru = id_pc + PC_STEP;
    end

    always_comb begin
        pc_d    = pc_q;
        base_d  = base_q;
        imme_d  = imme_q;
        taken_d = taken_q;
        flush_d = flush_q;
        err_d   = err_q;
        state_d = state_q;
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (!stall) begin
            flush_d = 1'b0;
            pc_d    = pc_q + PC_STEP;

            if (resolving) begin
                if (ex_taken) begin
                    if (cnt_q[base_idx] != CNT_MAX) begin
                        cnt_d[base_idx] = cnt_q[base_idx] + CNT_WIDTH'(1);
                    end
                end else begin
                    if (cnt_q[base_idx] != '0) begin
                        cnt_d[base_idx] = cnt_q[base_idx] - CNT_WIDTH'(1);
                    end
                end
                state_d = ST_IDLE;
            end else if (ex_resolve) begin
                err_d = 1'b1;
            end

            if (resolving && mispred) begin
                // Anything ID presents this cycle is on the wrong path.
                pc_d    = ex_taken ? (base_q + imme_q) : (base_q + PC_STEP);
                flush_d = 1'b1;
            end else if (id_branch) begin
                if (state_q == ST_IDLE || resolving) begin
                    base_d  = id_pc;
                    imme_d  = id_imme;
                    taken_d = pred;
                    pc_d    = pred ? id_target : id_fallthru;
                    state_d = ST_PENDING;
                end else begin
                    pc_d = pc_q;
                end
            end else if (id_jmp) begin
                pc_d = id_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            base_q  <= '0;
            imme_q  <= '0;
            taken_q <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else begin
            pc_q    <= pc_d;
            base_q  <= base_d;
            imme_q  <= imme_d;
            taken_q <= taken_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            state_q <= state_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef IF_PRED_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (!stall && resolving) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (mispred) begin
                stat_mispred_d = stat_mispred_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

`default_nettype wire
